// File: rtl/nios_ram_fill_check_master.sv
// ---------------------------------------------------------------------------
// nios_ram_fill_check_master
//
// Avalon-MM master BIST engine for the single-port on-chip RAM slave (s1).
// On a start request it writes a deterministic pattern (seed + i) into a
// window of N words starting at base_addr (address wraps modulo the RAM
// size), then reads the same window back and compares every word against
// the pattern. At the end it reports pass/fail, a saturating mismatch count
// and the address of the first mismatching word.
//
// Ports
//   clk, reset        system clock; asynchronous active-high reset
//   start             one-cycle request, only honoured while idle
//   base_addr         first word address of the test window
//   word_count        number of words to test (values above 2^ADDR_W clamp)
//   seed              pattern seed; word i carries seed + i
//   busy              high from the cycle after start through the done cycle
//   done              one-cycle pulse at the end of a test
//   pass              1 when the last test saw no mismatch; held until start
//   err_count         mismatch count, saturating at 16'hFFFF
//   first_err_addr    address of the first mismatch (meaningful if pass==0)
//   avm_*             Avalon-MM master port towards the RAM slave
//   avm_readdata      slave read data, valid READ_LATENCY cycles after issue
// ---------------------------------------------------------------------------
module nios_ram_fill_check_master #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic                  avm_clken,
  input  logic [DATA_W-1:0]     avm_readdata
);

  localparam int CNT_W   = ADDR_W + 1;
  localparam int BE_W    = DATA_W / 8;
  localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [CNT_W-1:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]  DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DRAIN_W-1:0] DRAIN_ONE = {{(DRAIN_W-1){1'b0}}, 1'b1};
  localparam logic [DRAIN_W-1:0] DRAIN_INI = DRAIN_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Control state
  state_t               r_state;
  logic [ADDR_W-1:0]    r_base;
  logic [DATA_W-1:0]    r_seed;
  logic [CNT_W-1:0]     r_last;
  logic [CNT_W-1:0]     r_idx;
  logic [DRAIN_W-1:0]   r_drain;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [15:0]          r_err;
  logic [ADDR_W-1:0]    r_first;

  // Registered bus outputs
  logic                 r_cs;
  logic                 r_write;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_clken;

  // Compare pipeline: expectation of each read travels alongside the slave
  // latency so it meets avm_readdata in the cycle the data is valid.
  logic [READ_LATENCY-1:0] r_pvld;
  logic [DATA_W-1:0]       r_pdata [READ_LATENCY];
  logic [ADDR_W-1:0]       r_paddr [READ_LATENCY];

  logic [CNT_W-1:0]     w_words;
  logic                 w_issue_rd;
  logic                 w_mismatch;
  logic [15:0]          w_err_next;

  // Oversized requests are clamped to the whole RAM.
  always_comb begin
    w_words = word_count;
    if (word_count > MAX_WORDS) begin
      w_words = MAX_WORDS;
    end
  end

  // The registered bus outputs describe the transfer on the bus this cycle,
  // so they are the natural source for the compare pipeline.
  assign w_issue_rd = r_cs & ~r_write;
  assign w_mismatch = r_pvld[READ_LATENCY-1] &&
                      (avm_readdata != r_pdata[READ_LATENCY-1]);
  assign w_err_next = (w_mismatch && (r_err != 16'hFFFF)) ? (r_err + 16'd1) : r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_seed  <= '0;
      r_last  <= '0;
      r_idx   <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
      r_cs    <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_clken <= 1'b0;
      r_pvld  <= '0;
    end else begin
      r_clken <= 1'b1;

      r_pvld[0] <= w_issue_rd;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pvld[k] <= r_pvld[k-1];
      end

      // Compare stage; the IDLE start branch below overrides these clears.
      r_err <= w_err_next;
      if (w_mismatch && (r_err == 16'd0)) begin
        r_first <= r_paddr[READ_LATENCY-1];
      end

      case (r_state)
        S_IDLE: begin
          r_cs   <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_base  <= base_addr;
            r_seed  <= seed;
            r_last  <= w_words - CNT_ONE;
            r_idx   <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
            r_first <= '0;
            r_busy  <= 1'b1;
            if (w_words == '0) begin
              // Empty window: report an immediate clean result.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_WRITE;
              r_cs    <= 1'b1;
              r_write <= 1'b1;
              r_addr  <= base_addr;
              r_wdata <= seed;
            end
          end
        end

        S_WRITE: begin
          if (r_idx == r_last) begin
            // Rewind to the window start for the read-back pass.
            r_state <= S_READ;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_addr  <= r_base;
            r_wdata <= r_seed;
          end else begin
            r_idx   <= r_idx + CNT_ONE;
            r_addr  <= r_addr + ADDR_ONE;
            r_wdata <= r_wdata + DATA_ONE;
          end
        end

        S_READ: begin
          if (r_idx == r_last) begin
            r_state <= S_DRAIN;
            r_cs    <= 1'b0;
            r_drain <= DRAIN_INI;
          end else begin
            r_idx   <= r_idx + CNT_ONE;
            r_addr  <= r_addr + ADDR_ONE;
            r_wdata <= r_wdata + DATA_ONE;
          end
        end

        S_DRAIN: begin
          if (r_drain == '0) begin
            // The last compare lands on this same edge, so judge pass on
            // the updated count rather than the registered one.
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 16'd0);
          end else begin
            r_drain <= r_drain - DRAIN_ONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_cs    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Expected data/address ride the pipe without reset; only the valid bits
  // qualify them.
  always_ff @(posedge clk) begin
    r_pdata[0] <= r_wdata;
    r_paddr[0] <= r_addr;
    for (int k = 1; k < READ_LATENCY; k++) begin
      r_pdata[k] <= r_pdata[k-1];
      r_paddr[k] <= r_paddr[k-1];
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_first;
  assign avm_address    = r_addr;
  assign avm_byteenable = {BE_W{r_cs}};
  assign avm_chipselect = r_cs;
  assign avm_write      = r_write;
  assign avm_writedata  = r_wdata;
  assign avm_clken      = r_clken;

endmodule

// File: tb/tb_nios_ram_fill_check_master.sv
// ---------------------------------------------------------------------------
// Testbench for nios_ram_fill_check_master: a RAM slave model with optional
// read corruption, and a cycle-indexed reference model that predicts every
// bus cycle and the final result from the window parameters.
// ---------------------------------------------------------------------------
module tb_nios_ram_fill_check_master;

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] word_count;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [12:0] first_err_addr;
  logic [12:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_clken;
  logic [31:0] avm_readdata;

  nios_ram_fill_check_master dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- RAM slave model ----------------
  logic [31:0] mem [8192];
  bit          bad [8192];
  logic [31:0] flip_mask = 32'h0000_0001;
  logic [12:0] wq_addr [$];
  logic [31:0] wq_data [$];
  int          cs_cnt = 0;

  always @(posedge clk) begin
    if (avm_chipselect) cs_cnt = cs_cnt + 1;
    if (avm_chipselect && avm_write) begin
      mem[avm_address] <= avm_writedata;
      wq_addr.push_back(avm_address);
      wq_data.push_back(avm_writedata);
    end
    if (avm_chipselect && !avm_write)
      avm_readdata <= mem[avm_address] ^ (bad[avm_address] ? flip_mask : 32'h0);
    else
      avm_readdata <= $urandom;
  end

  // ---------------- reference model ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          t0;
  bit          mdl_active = 0;
  int          m_base, m_n, m_d, m_err, m_first, obs_done;
  logic [31:0] m_seed;
  bit          m_pass;

  always @(negedge clk) begin : cmp
    int           k;
    logic         ecs, ewr, ebusy, edone;
    logic [12:0]  eaddr;
    logic [31:0]  ewd;
    logic [127:0] av, ev;
    if (mdl_active) begin
      k     = cyc - t0 + 1;
      ecs   = (k >= 1) && (k <= 2 * m_n);
      ewr   = ecs && (k <= m_n);
      eaddr = ecs ? 13'((m_base + (ewr ? k - 1 : k - m_n - 1)) % 8192) : 13'h0;
      ewd   = ewr ? (m_seed + 32'(k - 1)) : 32'h0;
      edone = (k == m_d);
      ebusy = (k >= 1) && (k <= m_d);
      av = {avm_chipselect, (ecs ? avm_write : 1'b0), (ecs ? avm_address : 13'h0),
            (ewr ? avm_writedata : 32'h0), busy, done, avm_byteenable, avm_clken};
      ev = {ecs, ewr, eaddr, ewd, ebusy, edone, (ecs ? 4'hF : 4'h0), 1'b1};
      chk($sformatf("cycle%0d_bus", k), av, ev);
      if (done && obs_done < 0) obs_done = k;
      if (k == m_d)
        chk("result", {pass, err_count, (m_pass ? 13'h0 : first_err_addr)},
            {m_pass, 16'(m_err), (m_pass ? 13'h0 : 13'(m_first))});
      if (k >= m_d + 3) mdl_active = 0;
    end
  end

  task automatic clear_bad();
    for (int i = 0; i < 8192; i++) bad[i] = 0;
  endtask

  task automatic run_test(input int base, input int n_req, input logic [31:0] sd,
                          input bit pulses, input int abort_k, input int abort_err);
    int k;
    wq_addr.delete();
    wq_data.delete();
    cs_cnt   = 0;
    obs_done = -1;
    flip_mask = $urandom | 32'h1;
    m_base = base;
    m_n    = (n_req > 8192) ? 8192 : n_req;
    m_seed = sd;
    m_d    = (m_n == 0) ? 1 : 2 * m_n + 2;
    m_err  = 0;
    m_first = 0;
    for (int i = 0; i < m_n; i++) begin
      if (bad[(base + i) % 8192]) begin
        if (m_err == 0) m_first = (base + i) % 8192;
        m_err++;
      end
    end
    if (m_err > 65535) m_err = 65535;
    m_pass = (m_err == 0);

    @(negedge clk);
    start      = 1'b1;
    base_addr  = 13'(base);
    word_count = 14'(n_req);
    seed       = sd;
    @(posedge clk);
    #1;
    start      = 1'b0;
    t0         = cyc;
    mdl_active = 1;
    base_addr  = 13'($urandom);
    word_count = 14'($urandom);
    seed       = $urandom;

    forever begin
      @(negedge clk);
      #1;
      if (!mdl_active) break;
      k = cyc - t0 + 1;
      if (abort_k > 0 && k == abort_k) begin
        mdl_active = 0;
        start = 1'b0;
        chk("abort_err_before_reset", 128'(err_count), 128'(abort_err));
        reset = 1'b1;
        #1;
        chk("abort_async_clear", {avm_chipselect, busy, done, err_count, avm_clken}, 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_bus", {avm_chipselect, busy, done}, 128'h0);
        end
        break;
      end
      start = pulses && (k <= m_d) && ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    logic [31:0] s;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    seed       = '0;
    clear_bad();
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus", {avm_chipselect, avm_write, avm_address, avm_writedata,
                      avm_byteenable, avm_clken}, 128'h0);
    chk("reset_status", {busy, done, pass, err_count, first_err_addr}, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {avm_clken, busy, avm_chipselect}, {1'b1, 1'b0, 1'b0});

    // 1: clean fill of four words at address 0
    run_test(0, 4, 32'h1000, 0, 0, 0);
    chk("t1_done_cycle", 128'(obs_done), 128'd10);
    chk("t1_write_data", {wq_data[0], wq_data[1], wq_data[2], wq_data[3]},
        {32'h1000, 32'h1001, 32'h1002, 32'h1003});
    chk("t1_write_addr", {wq_addr[0], wq_addr[1], wq_addr[2], wq_addr[3]},
        {13'h0, 13'h1, 13'h2, 13'h3});
    chk("t1_result", {pass, err_count}, {1'b1, 16'd0});

    // 2: one corrupted word
    bad[2] = 1;
    run_test(0, 4, 32'h1000, 0, 0, 0);
    chk("t2_result", {pass, err_count, first_err_addr}, {1'b0, 16'd1, 13'h2});
    clear_bad();

    // 3: window wrapping the top of the address space
    run_test(13'h1FFE, 4, 32'hDEAD_BEEF, 0, 0, 0);
    chk("t3_wrap_addr", {wq_addr[0], wq_addr[1], wq_addr[2], wq_addr[3]},
        {13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001});
    chk("t3_result", {pass, err_count}, {1'b1, 16'd0});

    // 4: empty window and start pulses while busy
    run_test(50, 0, 32'h55, 1, 0, 0);
    chk("t4_done_cycle", 128'(obs_done), 128'd1);
    chk("t4_no_bus", 128'(cs_cnt), 128'd0);
    chk("t4_pass", 128'(pass), 128'd1);
    run_test(7, 5, 32'hFFFF_FFFE, 1, 0, 0);
    chk("t4_one_run_only", 128'(cs_cnt), 128'd10);

    // 5: reset during the read phase, then a clean rerun
    for (int i = 100; i < 104; i++) bad[i] = 1;
    run_test(100, 16, 32'h77, 0, 22, 4);
    clear_bad();
    run_test(100, 16, 32'h77, 0, 0, 0);
    chk("t5_rerun_result", {pass, err_count}, {1'b1, 16'd0});

    // random windows with sparse corruption
    for (int r = 0; r < 10; r++) begin
      int n;
      clear_bad();
      b = $urandom_range(0, 8191);
      n = $urandom_range(0, 40);
      s = $urandom;
      for (int i = 0; i < n; i++)
        if ($urandom_range(0, 7) == 0) bad[(b + i) % 8192] = 1;
      run_test(b, n, s, 1, 0, 0);
    end

    // 6: whole RAM, every read corrupted
    for (int i = 0; i < 8192; i++) bad[i] = 1;
    b = 5000;
    run_test(b, 8192, 32'h1234_5678, 0, 0, 0);
    chk("t6_done_cycle", 128'(obs_done), 128'd16386);
    chk("t6_result", {pass, err_count, first_err_addr}, {1'b0, 16'd8192, 13'd5000});

    // oversized word_count clamps to the whole RAM
    clear_bad();
    bad[10] = 1;
    bad[300] = 1;
    run_test(200, 9000, 32'hCAFE_0000, 0, 0, 0);
    chk("clamp_done_cycle", 128'(obs_done), 128'd16386);
    chk("clamp_result", {pass, err_count, first_err_addr}, {1'b0, 16'd2, 13'd300});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
